// File: rtl/cyclicinv.sv
// cyclicinv: inverse of an NCYCLE-way interleaved recursive averager.
// For each slot the raw input is rebuilt as x = y_prev + 2^LGALPHA * (y - y_prev),
// where y_prev is the last averaged sample seen on that slot.
// After reset, a CLEAR sequence loads every slot history with RESET_VALUE before
// samples are accepted. The four-stage pipeline then runs at full rate.
// Optional feature macro: CYCLICINV_SATURATE_EN
//   defined   -> output clips to the OW-bit signed range, o_ovfl is a sticky clip flag
//   undefined -> output wraps to the low OW bits, o_ovfl is tied low
module cyclicinv #(
  parameter int unsigned    IW          = 16,
  parameter int unsigned    OW          = IW + 2,
  parameter int unsigned    LGALPHA     = 4,
  parameter int unsigned    NCYCLE      = 8,
  parameter logic [IW-1:0]  RESET_VALUE = '0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic [IW-1:0]             i_data,
  output logic                      o_busy,
  output logic                      o_ce,
  output logic [$clog2(NCYCLE)-1:0] o_slot,
  output logic [OW-1:0]             o_data,
  output logic                      o_ovfl
);

  localparam int unsigned SW = $clog2(NCYCLE);
  localparam int unsigned DW = IW + 1;
  localparam int unsigned AW = IW + LGALPHA + 2;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NCYCLE - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // Shared slot pointer: walks the memory during CLEAR, then tracks the live slot
  logic [SW-1:0] idx;

  logic clr_we;
  logic accept;

  logic [IW-1:0] mem [NCYCLE];

  // Stage E0 results
  logic                 v1;
  logic signed [IW-1:0] r_y;
  logic signed [IW-1:0] r_prev;
  logic [SW-1:0]        r_slot1;

  // Stage E1 results
  logic                 v2;
  logic signed [DW-1:0] diff;
  logic signed [IW-1:0] prev2;
  logic [SW-1:0]        slot2;

  // Stage E2 results
  logic                 v3;
  logic signed [AW-1:0] sum;
  logic [SW-1:0]        slot3;

  logic [OW-1:0] fit_c;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: CLEAR finishes on the write of the last slot, RUN holds until reset
  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: begin
        if (idx == LAST_SLOT) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        state_nx = S_RUN;
      end
      default: begin
        state_nx = S_CLEAR;
      end
    endcase
  end

  // FSM outputs: history write during CLEAR, sample acceptance during RUN
  always_comb begin
    clr_we = 1'b0;
    accept = 1'b0;
    case (state)
      S_CLEAR: clr_we = 1'b1;
      S_RUN:   accept = i_ce;
      default: clr_we = 1'b0;
    endcase
  end

  // Slot pointer and busy flag; pointer wraps naturally since NCYCLE is a power of two
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx    <= '0;
      o_busy <= 1'b1;
    end else begin
      o_busy <= (state_nx == S_CLEAR);
      if (clr_we || accept) begin
        idx <= idx + SW'(1);
      end
    end
  end

  // Per-slot history memory: cleared slot by slot, then overwritten by each new sample
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (clr_we) begin
        mem[idx] <= RESET_VALUE;
      end else if (accept) begin
        mem[idx] <= i_data;
      end
    end
  end

  // Pipeline valid chain; reset drops anything in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      o_ce <= 1'b0;
    end else begin
      v1   <= accept;
      v2   <= v1;
      v3   <= v2;
      o_ce <= v3;
    end
  end

  // E0: capture sample and the slot's previous value (read before the same-edge write)
  always_ff @(posedge i_clk) begin
    if (accept) begin
      r_y     <= i_data;
      r_prev  <= mem[idx];
      r_slot1 <= idx;
    end
  end

  // E1: exact difference against the slot history
  always_ff @(posedge i_clk) begin
    if (v1) begin
      diff  <= DW'(r_y) - DW'(r_prev);
      prev2 <= r_prev;
      slot2 <= r_slot1;
    end
  end

  // E2: scale the difference by 2^LGALPHA and add the history back
  always_ff @(posedge i_clk) begin
    if (v2) begin
      sum   <= AW'(prev2) + (AW'(diff) <<< LGALPHA);
      slot3 <= slot2;
    end
  end

`ifdef CYCLICINV_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  logic clip_c;

  // Clip the exact sum to the output range and flag when clipping happens
  always_comb begin
    fit_c  = sum[OW-1:0];
    clip_c = 1'b0;
    if (sum > SAT_HI) begin
      fit_c  = SAT_HI[OW-1:0];
      clip_c = 1'b1;
    end else if (sum < SAT_LO) begin
      fit_c  = SAT_LO[OW-1:0];
      clip_c = 1'b1;
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ovfl <= 1'b0;
    end else if (v3 && clip_c) begin
      o_ovfl <= 1'b1;
    end
  end
`else
  assign fit_c  = OW'(sum);
  assign o_ovfl = 1'b0;
`endif

  // E3: register the fitted output; data and slot hold between strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= '0;
      o_slot <= '0;
    end else if (v3) begin
      o_data <= fit_c;
      o_slot <= slot3;
    end
  end

endmodule

// File: tb/tb_cyclicinv.sv
// Bench for cyclicinv (defaults IW=16, OW=18, LGALPHA=4, NCYCLE=8).
// Directed table plus a cyclic-averager round trip, all checked through a scoreboard queue.
module tb_cyclicinv;

  logic               clk  = 1'b0;
  logic               rst  = 1'b1;
  logic               ce   = 1'b0;
  logic [15:0]        din  = '0;
  logic               busy;
  logic               oce;
  logic               ovfl;
  logic [2:0]         oslot;
  logic signed [17:0] odata;

  cyclicinv dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_ce    (ce),
    .i_data  (din),
    .o_busy  (busy),
    .o_ce    (oce),
    .o_slot  (oslot),
    .o_data  (odata),
    .o_ovfl  (ovfl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]         slot;
    logic signed [17:0] data;
    int                 cyc;
    bit                 rt;
    int                 orig;
  } exp_t;

  typedef struct {
    logic signed [15:0] y;
    logic [2:0]         slot;
    logic signed [17:0] data;
  } vec_t;

  exp_t               sbq[$];
  exp_t               mon_e;
  vec_t               tbl[20];
  logic signed [15:0] hist[8];
  logic [2:0]         m_idx = '0;
  logic signed [17:0] last_data = '0;
  int                 enc[8];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic signed [17:0] fit18(input longint s);
`ifdef CYCLICINV_SATURATE_EN
    if (s > 64'sd131071)  return 18'sd131071;
    if (s < -64'sd131072) return -18'sd131072;
`endif
    return 18'(s);
  endfunction

  // Reference reconstruction from the bench's own copy of the slot history
  function automatic logic signed [17:0] model(input logic signed [15:0] y);
    longint p;
    longint s;
    p = longint'(hist[m_idx]);
    s = p + (longint'(y) - p) * 16;
    return fit18(s);
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected sample
  always @(negedge clk) begin
    if (!rst && oce) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_o_ce: got o_ce=1 at cycle %0d expected no strobe", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("o_data", longint'(odata), longint'(mon_e.data));
        chk("o_slot", longint'(oslot), longint'(mon_e.slot));
        chk("latency", longint'(cyc), longint'(mon_e.cyc));
        if (mon_e.rt) begin
          checks++;
          if ((int'(odata) - mon_e.orig > 16) || (mon_e.orig - int'(odata) > 16)) begin
            errors++;
            $display("FAIL round_trip: got %0d expected %0d +/-16", odata, mon_e.orig);
          end
        end
        last_data = mon_e.data;
      end
    end
  end

  task automatic send(input logic signed [15:0] y, input logic signed [17:0] e,
                      input logic [2:0] slot, input bit rt, input int orig);
    @(negedge clk);
    ce  = 1'b1;
    din = y;
    sbq.push_back('{slot: slot, data: e, cyc: cyc + 4, rt: rt, orig: orig});
    hist[m_idx] = y;
    m_idx = m_idx + 3'd1;
  endtask

  task automatic idle();
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    idle();
  endtask

  // Reset, check reset state, then count busy cycles (optionally with junk strobes)
  task automatic do_reset(input bit junk);
    int n;
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    @(negedge clk);
    chk("rst_o_ce", longint'(oce), 0);
    chk("rst_o_slot", longint'(oslot), 0);
    chk("rst_o_data", longint'(odata), 0);
    chk("rst_o_ovfl", longint'(ovfl), 0);
    chk("rst_o_busy", longint'(busy), 1);
    rst = 1'b0;
    ce  = junk;
    din = 16'h7abc;
    n   = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) n++;
      else break;
      @(negedge clk);
    end
    ce = 1'b0;
    chk("busy_cycles", longint'(n), 8);
    m_idx = '0;
    for (int k = 0; k < 8; k++) hist[k] = '0;
  endtask

  initial begin
    tbl[0]  = '{16'sd100,    3'd0, 18'sd1600};
    tbl[1]  = '{16'sd100,    3'd1, 18'sd1600};
    tbl[2]  = '{-16'sd3,     3'd2, -18'sd48};
    tbl[3]  = '{16'sd0,      3'd3, 18'sd0};
`ifdef CYCLICINV_SATURATE_EN
    tbl[4]  = '{16'sd32767,  3'd4, 18'sd131071};
    tbl[5]  = '{-16'sd32768, 3'd5, -18'sd131072};
`else
    tbl[4]  = '{16'sd32767,  3'd4, -18'sd16};
    tbl[5]  = '{-16'sd32768, 3'd5, 18'sd0};
`endif
    tbl[6]  = '{16'sd7,      3'd6, 18'sd112};
    tbl[7]  = '{16'sd1,      3'd7, 18'sd16};
    tbl[8]  = '{16'sd100,    3'd0, 18'sd100};
    tbl[9]  = '{16'sd100,    3'd1, 18'sd100};
    tbl[10] = '{-16'sd3,     3'd2, -18'sd3};
    tbl[11] = '{16'sd10,     3'd3, 18'sd160};
    tbl[12] = '{16'sd32767,  3'd4, 18'sd32767};
    tbl[13] = '{-16'sd32768, 3'd5, -18'sd32768};
    tbl[14] = '{16'sd6,      3'd6, -18'sd9};
    tbl[15] = '{-16'sd1,     3'd7, -18'sd31};
    tbl[16] = '{16'sd101,    3'd0, 18'sd116};
    tbl[17] = '{16'sd0,      3'd1, -18'sd1500};
`ifdef CYCLICINV_SATURATE_EN
    tbl[18] = '{-16'sd32768, 3'd2, -18'sd131072};
    tbl[19] = '{16'sd32767,  3'd3, 18'sd131071};
`else
    tbl[18] = '{-16'sd32768, 3'd2, 18'sd45};
    tbl[19] = '{16'sd32767,  3'd3, -18'sd166};
`endif

    // Clear sequence with strobes held high; none may be accepted
    do_reset(1'b1);

    // Back-to-back table at full rate
    foreach (tbl[i]) send(tbl[i].y, tbl[i].data, tbl[i].slot, 1'b0, 0);
    idle();
    drain();
    repeat (4) idle();
    chk("hold_o_ce", longint'(oce), 0);
    chk("hold_o_data", longint'(odata), longint'(last_data));
`ifdef CYCLICINV_SATURATE_EN
    chk("ovfl_sticky", longint'(ovfl), 1);
`else
    chk("ovfl_tied", longint'(ovfl), 0);
`endif

    // Reset in the middle of CLEAR restarts the sweep
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_reset(1'b0);

    // Reset with three samples in flight: they must vanish
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ce  = 1'b1;
      din = 16'(300 + k);
    end
    do_reset(1'b0);
    send(16'sd5, 18'sd80, 3'd0, 1'b0, 0);
    idle();
    drain();

    // Round trip through a rounding cyclic averager model
    for (int k = 0; k < 8; k++) enc[k] = int'(hist[k]);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        int x;
        int yp;
        int yn;
        x  = int'($urandom_range(0, 65535)) - 32768;
        yp = enc[m_idx];
        yn = yp + ((x - yp + 8) >>> 4);
        enc[m_idx] = yn;
        send(16'(yn), model(16'(yn)), m_idx, 1'b1, x);
      end else begin
        idle();
      end
    end
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
